// File: rtl/rename_pkg.sv
// Shared types, sizes and reset constants for the register-rename stage.
package rename_pkg;

    localparam int unsigned N_ARCH = 8;
    localparam int unsigned N_PHYS = 16;

    typedef logic [2:0]  arch_idx_t;
    typedef logic [3:0]  phys_tag_t;
    typedef logic [15:0] free_vec_t;
    typedef phys_tag_t [N_ARCH-1:0] rat_t;

    // Identity mapping: architectural register i lives in physical register i.
    localparam rat_t RAT_RESET = {4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    localparam free_vec_t FREE_RESET = 16'hFF00;

    function automatic logic [4:0] popcount16(input free_vec_t v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    // One-hot OR of every tag referenced by a mapping table.
    function automatic free_vec_t rat_used(input rat_t r);
        free_vec_t u;
        u = '0;
        for (int i = 0; i < int'(N_ARCH); i++) begin
            u[r[i]] = 1'b1;
        end
        return u;
    endfunction

endpackage

// File: rtl/prio_enc16.sv
// Lowest-set-bit priority encoder over the 16-entry free bitmap.
module prio_enc16
    import rename_pkg::*;
(
    input  free_vec_t free,
    output phys_tag_t idx,
    output logic      valid
);

    // Scan from the top so the lowest set bit is the last one to win.
    always_comb begin
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (free[i]) begin
                idx = i[3:0];
            end
        end
        valid = |free;
    end

endmodule

// File: rtl/rename_unit.sv
// Single-issue register rename: speculative RAT, committed RAT, bitmap free list.
// Optional macro RENAME_RETIRE_BYPASS_EN lets a same-cycle retired tag feed an
// allocation when the free list is otherwise empty.
module rename_unit
    import rename_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    input  logic       RegWr_in,
    input  arch_idx_t  Ra_in,
    input  arch_idx_t  Rb_in,
    input  arch_idx_t  Rw_in,
    output logic       ready_out,
    input  logic       rob_full,
    input  logic       flush,
    output logic       valid_out,
    output arch_idx_t  Rw_out,
    output phys_tag_t  tag_Ra,
    output phys_tag_t  tag_Rb,
    output phys_tag_t  tag_Rw_new,
    output phys_tag_t  tag_Rw_old,
    input  logic       RegWr_ret,
    input  arch_idx_t  Rw_ret,
    input  phys_tag_t  tag_PRF_ret,
    input  phys_tag_t  tag_Rw_old_ret,
    output logic [4:0] free_cnt
);

    rat_t      rat_q, rat_d, crat_q, crat_d;
    free_vec_t free_q, free_d;
    phys_tag_t enc_idx, alloc_tag;
    logic      enc_valid, alloc_ok, bypass_hit;
    logic      need_alloc, ret_en, fire, alloc;

    prio_enc16 u_enc (
        .free  (free_q),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign need_alloc = valid_in && RegWr_in && (Rw_in != '0);
    assign ret_en     = RegWr_ret && (Rw_ret != '0);

`ifdef RENAME_RETIRE_BYPASS_EN
    // Empty list: the tag being retired this cycle goes straight to the allocation.
    assign alloc_ok  = enc_valid || ret_en;
    assign alloc_tag = enc_valid ? enc_idx : tag_Rw_old_ret;
    assign bypass_hit = !enc_valid && ret_en && alloc;
`else
    assign alloc_ok   = enc_valid;
    assign alloc_tag  = enc_idx;
    assign bypass_hit = 1'b0;
`endif

    assign ready_out = !flush && !rob_full && (alloc_ok || !need_alloc);
    assign fire      = valid_in && ready_out;
    assign alloc     = fire && need_alloc;
    assign free_cnt  = popcount16(free_q);

    // Next-state for mapping tables and free list; flush overrides speculative updates.
    always_comb begin
        crat_d = crat_q;
        rat_d  = rat_q;
        free_d = free_q;
        if (ret_en) begin
            crat_d[Rw_ret] = tag_PRF_ret;
        end
        if (flush) begin
            rat_d  = crat_d;
            free_d = ~rat_used(crat_d);
        end else begin
            if (alloc) begin
                free_d[alloc_tag] = 1'b0;
                rat_d[Rw_in]      = alloc_tag;
            end
            // Set after clear so a freed bit wins over a same-cycle allocation.
            if (ret_en && !bypass_hit) begin
                free_d[tag_Rw_old_ret] = 1'b1;
            end
        end
    end

    // State registers and the registered rename packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rat_q      <= RAT_RESET;
            crat_q     <= RAT_RESET;
            free_q     <= FREE_RESET;
            valid_out  <= 1'b0;
            Rw_out     <= '0;
            tag_Ra     <= '0;
            tag_Rb     <= '0;
            tag_Rw_new <= '0;
            tag_Rw_old <= '0;
        end else begin
            rat_q     <= rat_d;
            crat_q    <= crat_d;
            free_q    <= free_d;
            valid_out <= fire;
            if (fire) begin
                Rw_out     <= Rw_in;
                tag_Ra     <= rat_q[Ra_in];
                tag_Rb     <= rat_q[Rb_in];
                tag_Rw_old <= rat_q[Rw_in];
                tag_Rw_new <= alloc ? alloc_tag : '0;
            end
        end
    end

`ifndef SYNTHESIS
    // A retired tag must not already be free, unless this cycle's allocation takes it.
    always @(posedge clk) begin
        if (!rst && ret_en) begin
            assert (!free_q[tag_Rw_old_ret] || (alloc && alloc_tag == tag_Rw_old_ret))
                else $error("rename_unit: double free of tag %0d", tag_Rw_old_ret);
        end
    end
`endif

endmodule

// File: tb/tb_rename_unit.sv
// Scoreboard bench for rename_unit: driver pushes expected packets, monitor pops them.
module tb_rename_unit;
    import rename_pkg::*;

    typedef struct packed {
        logic [2:0] rw;
        logic [3:0] ta;
        logic [3:0] tb;
        logic [3:0] tn;
        logic [3:0] to;
        logic [4:0] fc;
    } pkt_t;

    logic       clk, rst;
    logic       valid_in, RegWr_in, rob_full, flush, RegWr_ret;
    arch_idx_t  Ra_in, Rb_in, Rw_in, Rw_ret, Rw_out;
    phys_tag_t  tag_PRF_ret, tag_Rw_old_ret;
    phys_tag_t  tag_Ra, tag_Rb, tag_Rw_new, tag_Rw_old;
    logic       ready_out, valid_out;
    logic [4:0] free_cnt;

    int   n_cmp = 0;
    int   n_err = 0;
    pkt_t q[$];

    rename_unit dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .RegWr_in       (RegWr_in),
        .Ra_in          (Ra_in),
        .Rb_in          (Rb_in),
        .Rw_in          (Rw_in),
        .ready_out      (ready_out),
        .rob_full       (rob_full),
        .flush          (flush),
        .valid_out      (valid_out),
        .Rw_out         (Rw_out),
        .tag_Ra         (tag_Ra),
        .tag_Rb         (tag_Rb),
        .tag_Rw_new     (tag_Rw_new),
        .tag_Rw_old     (tag_Rw_old),
        .RegWr_ret      (RegWr_ret),
        .Rw_ret         (Rw_ret),
        .tag_PRF_ret    (tag_PRF_ret),
        .tag_Rw_old_ret (tag_Rw_old_ret),
        .free_cnt       (free_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] rw, input logic [3:0] ta, tb, tn, to,
                        input logic [4:0] fc);
        q.push_back({rw, ta, tb, tn, to, fc});
    endtask

    task automatic set_ret(input logic [2:0] rw, input logic [3:0] prf, old);
        RegWr_ret      = 1'b1;
        Rw_ret         = rw;
        tag_PRF_ret    = prf;
        tag_Rw_old_ret = old;
    endtask

    // Present one instruction, check ready_out, cross one edge, then idle the side inputs.
    task automatic step(input string name, input logic v, wr, input logic [2:0] ra, rb, rw,
                        input logic exp_rdy);
        valid_in = v;
        RegWr_in = wr;
        Ra_in    = ra;
        Rb_in    = rb;
        Rw_in    = rw;
        #1;
        check({name, " ready_out"}, int'(ready_out), int'(exp_rdy));
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
        RegWr_in  = 1'b0;
        RegWr_ret = 1'b0;
        flush     = 1'b0;
        rob_full  = 1'b0;
    endtask

    // Monitor: every presented packet must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && valid_out) begin
            pkt_t act;
            act = {Rw_out, tag_Ra, tag_Rb, tag_Rw_new, tag_Rw_old, free_cnt};
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected packet: got %h expected none", act);
            end else begin
                pkt_t exp;
                exp = q.pop_front();
                if (act != exp) begin
                    n_err++;
                    $display("FAIL packet: got rw=%0d ta=%0d tb=%0d new=%0d old=%0d cnt=%0d expected rw=%0d ta=%0d tb=%0d new=%0d old=%0d cnt=%0d",
                             act.rw, act.ta, act.tb, act.tn, act.to, act.fc,
                             exp.rw, exp.ta, exp.tb, exp.tn, exp.to, exp.fc);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        valid_in = 0; RegWr_in = 0; Ra_in = 0; Rb_in = 0; Rw_in = 0;
        rob_full = 0; flush = 0; RegWr_ret = 0; Rw_ret = 0;
        tag_PRF_ret = 0; tag_Rw_old_ret = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset valid_out", int'(valid_out), 0);
        check("reset free_cnt", int'(free_cnt), 8);
        check("reset tag_Rw_new", int'(tag_Rw_new), 0);
        check("reset tag_Ra", int'(tag_Ra), 0);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic rename and one-cycle latency.
        push(3'd3, 4'd1, 4'd2, 4'd8, 4'd3, 5'd7);
        step("t1", 1, 1, 3'd1, 3'd2, 3'd3, 1);
        step("idle", 0, 0, 3'd0, 3'd0, 3'd0, 1);
        check("hold valid_out", int'(valid_out), 0);
        check("hold tag_Rw_new", int'(tag_Rw_new), 8);

        // Dependent rename sees the freshly allocated tag.
        push(3'd3, 4'd8, 4'd0, 4'd9, 4'd8, 5'd6);
        step("dep", 1, 1, 3'd3, 3'd0, 3'd3, 1);

        // Drain the free list.
        push(3'd1, 4'd0, 4'd0, 4'd10, 4'd1, 5'd5);
        step("w1", 1, 1, 3'd0, 3'd0, 3'd1, 1);
        push(3'd2, 4'd0, 4'd0, 4'd11, 4'd2, 5'd4);
        step("w2", 1, 1, 3'd0, 3'd0, 3'd2, 1);
        push(3'd4, 4'd0, 4'd0, 4'd12, 4'd4, 5'd3);
        step("w4", 1, 1, 3'd0, 3'd0, 3'd4, 1);
        push(3'd5, 4'd0, 4'd0, 4'd13, 4'd5, 5'd2);
        step("w5", 1, 1, 3'd0, 3'd0, 3'd5, 1);
        push(3'd6, 4'd0, 4'd0, 4'd14, 4'd6, 5'd1);
        step("w6", 1, 1, 3'd0, 3'd0, 3'd6, 1);
        push(3'd7, 4'd0, 4'd0, 4'd15, 4'd7, 5'd0);
        step("w7", 1, 1, 3'd0, 3'd0, 3'd7, 1);
        step("ninth", 1, 1, 3'd0, 3'd0, 3'd1, 0);
        check("empty free_cnt", int'(free_cnt), 0);

        // Non-writers still pass with an empty list; ROB full blocks them.
        push(3'd5, 4'd9, 4'd10, 4'd0, 4'd13, 5'd0);
        step("nowr", 1, 0, 3'd3, 3'd1, 3'd5, 1);
        push(3'd0, 4'd15, 4'd12, 4'd0, 4'd0, 5'd0);
        step("r0", 1, 1, 3'd7, 3'd4, 3'd0, 1);
        rob_full = 1'b1;
        step("robfull", 1, 0, 3'd0, 3'd0, 3'd5, 0);

        // Empty list plus retire of tag 3.
        set_ret(3'd3, 4'd8, 4'd3);
`ifdef RENAME_RETIRE_BYPASS_EN
        push(3'd1, 4'd10, 4'd11, 4'd3, 4'd10, 5'd0);
        step("bypass", 1, 1, 3'd1, 3'd2, 3'd1, 1);
`else
        step("ret stall", 1, 1, 3'd1, 3'd2, 3'd1, 0);
        check("ret free_cnt", int'(free_cnt), 1);
        push(3'd1, 4'd10, 4'd11, 4'd3, 4'd10, 5'd0);
        step("ret alloc", 1, 1, 3'd1, 3'd2, 3'd1, 1);
`endif

        // Flush with a same-cycle retire of r4 -> tag 12.
        set_ret(3'd4, 4'd12, 4'd4);
        flush = 1'b1;
        step("flush", 1, 1, 3'd0, 3'd0, 3'd2, 0);
        check("flush valid_out", int'(valid_out), 0);
        check("flush free_cnt", int'(free_cnt), 8);
        push(3'd4, 4'd8, 4'd12, 4'd3, 4'd12, 5'd7);
        step("post flush a", 1, 1, 3'd3, 3'd4, 3'd4, 1);
        push(3'd2, 4'd1, 4'd2, 4'd4, 4'd2, 5'd6);
        step("post flush b", 1, 1, 3'd1, 3'd2, 3'd2, 1);

        // Allocate tag 9 while retire frees tag 9: free wins, count unchanged.
        set_ret(3'd5, 4'd13, 4'd9);
        push(3'd6, 4'd0, 4'd0, 4'd9, 4'd6, 5'd6);
        step("same bit", 1, 1, 3'd0, 3'd0, 3'd6, 1);
        push(3'd7, 4'd0, 4'd0, 4'd9, 4'd7, 5'd5);
        step("after same", 1, 1, 3'd0, 3'd0, 3'd7, 1);
        step("drain", 0, 0, 3'd0, 3'd0, 3'd0, 1);

        // Asynchronous reset mid-operation.
        #2 rst = 1'b1;
        #1;
        check("async valid_out", int'(valid_out), 0);
        check("async free_cnt", int'(free_cnt), 8);
        check("async tag_Rw_old", int'(tag_Rw_old), 0);
        #1 rst = 1'b0;
        push(3'd3, 4'd3, 4'd5, 4'd8, 4'd3, 5'd7);
        step("after rst", 1, 1, 3'd3, 3'd5, 3'd3, 1);
        step("end", 0, 0, 3'd0, 3'd0, 3'd0, 1);
        @(posedge clk);
        #1;
        check("queue empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
